clk_div_sched: RTL and testbench

// - Run-time programmable clock divider with glitch-free ratio switching, for MAC_HW.
// - Produces a 50%-duty clk_o at clk_i/N for any N in 2..2^CNT_W-1, odd or even.
// - Also produces a one-cycle tick_o enable at each clk_o period start.
// - Owns the switch between ratios: a new N takes effect only at a period boundary, so clk_o never

---
 rtl/mac_clk_pkg.sv | 13 +
 rtl/clk_div_core.sv | 42 ++++
 rtl/clk_div_sched.sv | 117 +++++++++++
 tb/tb_clk_div_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_clk_pkg.sv
// rtl/mac_clk_pkg.sv - shared types and constants for the MAC clock divider scheduler
package mac_clk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        SWPEND
    } state_t;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter and 50%-duty clock generation for any ratio >= 2
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             clk_o
);

    logic pos_hi;
    logic neg_hi;

    // >= rather than == so a ratio shrunk below cnt while draining still ends the period
    assign last   = run && (cnt >= ratio - CNT_W'(1));
    assign pos_hi = run && (cnt < (ratio >> 1));

    always_ff @(posedge clk_i) begin
        if (!rst || !run) begin
            cnt <= '0;
        end else if (last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Half-cycle extension of the high window, only used for odd ratios
    always_ff @(negedge clk_i) begin
        if (!rst) begin
            neg_hi <= 1'b0;
        end else begin
            neg_hi <= pos_hi;
        end
    end

    assign clk_o = pos_hi | (ratio[0] & neg_hi);

endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - programmable divider with ratio switching deferred to period boundaries
module clk_div_sched
    import mac_clk_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic             div_req_i,
    input  logic [CNT_W-1:0] div_val_i,
    output logic             div_ack_o,
    output logic             div_err_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] ratio, ratio_nxt;
    logic [CNT_W-1:0] next_ratio, next_ratio_nxt;
    logic             ack_q, ack_nxt;
    logic             err_q, err_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             run;
    logic             accept;
    logic             val_ok;

    assign run = (state != IDLE);

    clk_div_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk_i (clk_i),
        .rst   (rst),
        .run   (run),
        .ratio (ratio),
        .cnt   (cnt),
        .last  (last),
        .clk_o (clk_o)
    );

    // The ack cycle blocks acceptance so a held request cannot be counted twice
    assign accept = div_req_i && !ack_q && (state != SWPEND);
    assign val_ok = (div_val_i >= CNT_W'(DIV_MIN));

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state      <= IDLE;
            ratio      <= CNT_W'(DIV_DEFAULT);
            next_ratio <= CNT_W'(DIV_DEFAULT);
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ratio      <= ratio_nxt;
            next_ratio <= next_ratio_nxt;
            ack_q      <= ack_nxt;
            err_q      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ratio_nxt      = ratio;
        next_ratio_nxt = next_ratio;
        ack_nxt        = 1'b0;
        err_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ack_nxt = 1'b1;
                    if (val_ok) ratio_nxt = div_val_i;
                    else        err_nxt   = 1'b1;
                end
                if (en_i) state_nxt = RUN;
            end
            RUN: begin
                if (accept && val_ok) begin
                    next_ratio_nxt = div_val_i;
                    state_nxt      = SWPEND;
                end else begin
                    if (accept) begin
                        ack_nxt = 1'b1;
                        err_nxt = 1'b1;
                    end
                    if (!en_i) state_nxt = last ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    ack_nxt = 1'b1;
                    if (val_ok) ratio_nxt = div_val_i;
                    else        err_nxt   = 1'b1;
                end
                if (en_i)      state_nxt = RUN;
                else if (last) state_nxt = IDLE;
            end
            SWPEND: begin
                if (last) begin
                    ratio_nxt = next_ratio;
                    ack_nxt   = 1'b1;
                    state_nxt = en_i ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tick_o    = (cnt == '0) && ((state == RUN) || (state == SWPEND));
    assign busy_o    = run;
    assign div_ack_o = ack_q;
    assign div_err_o = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - directed and random checks of clk_div_sched against a period-level model
module tb_clk_div_sched;

    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 2;

    logic             clk_i;
    logic             rst;
    logic             en_i;
    logic             div_req_i;
    logic [CNT_W-1:0] div_val_i;
    logic             div_ack_o;
    logic             div_err_o;
    logic             clk_o;
    logic             tick_o;
    logic             busy_o;

    clk_div_sched #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .en_i      (en_i),
        .div_req_i (div_req_i),
        .div_val_i (div_val_i),
        .div_ack_o (div_ack_o),
        .div_err_o (div_err_o),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .busy_o    (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: position inside the current output period and its length in clk_i cycles
    bit m_run, m_stop, m_ack, m_err;
    int m_pos, m_len, m_pend;

    int cyc = 0;
    int last_tick = -1000;
    int tick_gap = 0;
    int hi_cnt = 0;
    int last_hi = 0;
    bit ack_seen = 0;
    bit ack_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit acc, ok, bnd, na, ne;
        if (!rst) begin
            m_run = 0; m_stop = 0; m_ack = 0; m_err = 0;
            m_pos = 0; m_len = DIV_DEFAULT; m_pend = 0;
            return;
        end
        acc = div_req_i && !m_ack && (m_pend == 0);
        ok  = (div_val_i >= 2);
        bnd = m_run && (m_pos == m_len - 1);
        na  = 0;
        ne  = 0;
        if (!m_run) begin
            if (acc) begin
                na = 1;
                if (ok) m_len = int'(div_val_i);
                else    ne = 1;
            end
            if (en_i) begin
                m_run  = 1;
                m_stop = 0;
            end
            m_pos = 0;
        end else if (m_pend != 0) begin
            if (bnd) begin
                m_len  = m_pend;
                m_pend = 0;
                na     = 1;
                m_pos  = 0;
                m_run  = en_i;
            end else begin
                m_pos++;
            end
        end else if (!m_stop && acc && ok) begin
            m_pend = int'(div_val_i);
            m_pos  = bnd ? 0 : m_pos + 1;
        end else begin
            if (acc) begin
                na = 1;
                if (ok) m_len = int'(div_val_i);
                else    ne = 1;
            end
            if (bnd) begin
                m_pos  = 0;
                m_stop = 0;
                if (!en_i) m_run = 0;
            end else begin
                m_pos++;
                m_stop = !en_i;
            end
        end
        m_ack = na;
        m_err = ne;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        cyc++;
        #1;
        chk("busy", busy_o, m_run);
        chk("tick", tick_o, m_run && !m_stop && (m_pos == 0));
        chk("ack", div_ack_o, m_ack);
        chk("err", div_err_o, m_err);
        chk("clk_first_half", clk_o, m_run && (2 * m_pos < m_len));
        ack_seen = div_ack_o;
        if (div_ack_o) ack_err = div_err_o;
        if (tick_o) begin
            tick_gap  = cyc - last_tick;
            last_tick = cyc;
            last_hi   = hi_cnt;
            hi_cnt    = 0;
        end
        if (clk_o) hi_cnt++;
        @(negedge clk_i);
        #1;
        chk("clk_second_half", clk_o, m_run && (2 * m_pos + 1 < m_len));
        if (clk_o) hi_cnt++;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int v);
        bit got;
        got       = 0;
        div_req_i = 1'b1;
        div_val_i = v[CNT_W-1:0];
        for (int i = 0; i < 200; i++) begin
            step();
            if (ack_seen) begin
                got = 1;
                break;
            end
        end
        chk("ack_within_bound", got, 1);
        div_req_i = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        bit got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            if (m_run && !m_stop && m_pend == 0 && m_pos == p) begin
                got = 1;
                break;
            end
            step();
        end
        chk("reach_position", got, 1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            if (!m_run) begin
                got = 1;
                break;
            end
            step();
        end
        chk("reach_idle", got, 1);
    endtask

    initial begin
        rst       = 1'b0;
        en_i      = 1'b0;
        div_req_i = 1'b0;
        div_val_i = '0;

        // Reset default ratio 2
        run_cycles(3);
        chk("reset_busy", busy_o, 0);
        chk("reset_clk", clk_o, 0);
        rst  = 1'b1;
        en_i = 1'b1;
        run_cycles(12);
        chk("default_period", tick_gap, 2);
        chk("default_high_halves", last_hi, 2);

        // Odd ratio programmed while idle
        en_i = 1'b0;
        wait_idle();
        request(5);
        chk("odd_ack_err", ack_err, 0);
        en_i = 1'b1;
        run_cycles(22);
        chk("odd_period", tick_gap, 5);
        chk("odd_high_halves", last_hi, 5);

        // Switch 4 -> 7 requested at cnt==1
        request(4);
        run_cycles(10);
        wait_pos(1);
        request(7);
        chk("pre_switch_period", tick_gap, 4);
        run_cycles(16);
        chk("post_switch_period", tick_gap, 7);
        chk("post_switch_high_halves", last_hi, 7);

        // Bad ratios while running N=3
        request(3);
        run_cycles(6);
        request(1);
        chk("bad1_err", ack_err, 1);
        request(0);
        chk("bad0_err", ack_err, 1);
        run_cycles(10);
        chk("bad_keeps_period", tick_gap, 3);

        // Drain with N=6, then re-enable inside a draining period
        request(6);
        run_cycles(8);
        wait_pos(1);
        en_i = 1'b0;
        wait_idle();
        run_cycles(4);
        chk("drained_busy", busy_o, 0);
        chk("drained_clk", clk_o, 0);
        en_i = 1'b1;
        run_cycles(8);
        wait_pos(1);
        en_i = 1'b0;
        run_cycles(2);
        en_i = 1'b1;
        run_cycles(12);
        chk("reenable_no_gap", tick_gap, 6);

        // Reset while a switch is pending
        div_req_i = 1'b1;
        div_val_i = 8'd9;
        for (int i = 0; i < 20 && m_pend == 0; i++) step();
        chk("switch_pending", m_pend, 9);
        rst = 1'b0;
        run_cycles(2);
        div_req_i = 1'b0;
        rst = 1'b1;
        en_i = 1'b0;
        run_cycles(3);
        chk("post_reset_idle", busy_o, 0);
        en_i = 1'b1;
        run_cycles(10);
        chk("post_reset_period", tick_gap, 2);

        // Random traffic; requests never overlap a drain so the model stays period-exact
        for (int i = 0; i < 2000; i++) begin
            if (div_req_i && ack_seen) begin
                if ($urandom_range(3) == 0) begin
                    div_val_i = ($urandom_range(4) == 0) ? CNT_W'($urandom_range(1))
                                                         : CNT_W'($urandom_range(2, 12));
                end else begin
                    div_req_i = 1'b0;
                end
            end else if (!div_req_i && !m_stop && $urandom_range(15) == 0) begin
                div_req_i = 1'b1;
                div_val_i = ($urandom_range(4) == 0) ? CNT_W'($urandom_range(1))
                                                     : CNT_W'($urandom_range(2, 12));
            end
            if ($urandom_range(30) == 0) begin
                if (en_i && !div_req_i) en_i = 1'b0;
                else                    en_i = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
